serial_sample_assembler: RTL and testbench
==========================================

SERIAL_SAMPLE_ASSEMBLER -- requirements
Module: serial_sample_assembler

Interface
REQ-001 The block SHALL have parameter NUM_GROUPS, default 6, giving the number of 4-lane sample groups per load (NUM_GROUPS*4 byte entries downstream).
REQ-002 The block SHALL have parameter IDX_W, default 32, giving the width of the sample index output.
REQ-003 The block SHALL have port iClock, input, 1 bit: the single clock; all logic on its rising edge.
REQ-004 The block SHALL have port iResetN, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port iByte, input, 8 bits: received serial byte.
REQ-006 The block SHALL have port iByteValid, input, 1 bit: iByte is valid this cycle.
REQ-007 The block SHALL have port oByteReady, output, 1 bit: a byte is accepted this cycle when iByteValid and oByteReady are both high.
REQ-008 The block SHALL have port iStart, input, 1 bit: a one-cycle pulse that begins a new load.
REQ-009 The block SHALL have port iNextSample, input, 1 bit: the downstream storage stage is idle.
REQ-010 The block SHALL have port oPreparingNextSample, output, 1 bit: request pulse to the downstream stage.
REQ-011 The block SHALL have port oWriteSample, output, 1 bit: write strobe to the downstream stage.
REQ-012 The block SHALL have port oCurrentSerialInput, output, 4x8 bits: input lanes 0..3.
REQ-013 The block SHALL have port oCurrentSerialExpectedOutput, output, 4x8 bits: expected-output lanes 0..3.
REQ-014 The block SHALL have port oCurrentSerialValidOutput, output, 4x8 bits: valid-mask lanes 0..3.
REQ-015 The block SHALL have port oSampleIndex, output, IDX_W bits: the group index being written.
REQ-016 The block SHALL have port oDone, output, 1 bit: all NUM_GROUPS groups have been written.
REQ-017 The block SHALL have port oOverrun, output, 1 bit: sticky flag, a byte was offered while not ready.

Function
REQ-018 The block SHALL implement the states IDLE, COLLECT, REQUEST, WRITE and DONE.
REQ-019 IDLE: oByteReady SHALL be 0; on iStart=1 the block SHALL clear the byte count, oSampleIndex and oOverrun, and go to COLLECT.
REQ-020 COLLECT: oByteReady SHALL be 1; each accepted byte SHALL be stored at position byte count (0..11), then the byte count SHALL increment.
REQ-021 Byte mapping: positions 0-3 SHALL go to input lanes 0-3, positions 4-7 to expected lanes 0-3, and positions 8-11 to valid lanes 0-3.
REQ-022 When the 12th byte (position 11) is accepted, the block SHALL go to REQUEST on the next cycle and reset the byte count to 0.
REQ-023 REQUEST: oByteReady SHALL be 0; while iNextSample=0 the block SHALL stay in REQUEST with oPreparingNextSample=0.
REQ-024 REQUEST: in the first cycle with iNextSample=1, oPreparingNextSample SHALL be 1 for exactly that cycle, and the block SHALL go to WRITE.
REQ-025 WRITE: oWriteSample SHALL be 1 for exactly one cycle, the lane outputs and oSampleIndex SHALL be stable, and oPreparingNextSample SHALL be 0.
REQ-026 After WRITE, oSampleIndex SHALL increment by 1.
REQ-027 After WRITE, if the new index equals NUM_GROUPS the block SHALL go to DONE; otherwise it SHALL go to COLLECT.
REQ-028 Lane outputs and oSampleIndex SHALL change only in COLLECT and on leaving WRITE; they SHALL hold constant from REQUEST entry through the end of WRITE.
REQ-029 DONE: oDone SHALL be 1 and oByteReady SHALL be 0; on iStart=1 the block SHALL behave as in IDLE, clearing oDone and starting a new load.
REQ-030 iStart asserted in COLLECT, REQUEST or WRITE SHALL be ignored.
REQ-031 iByteValid=1 while oByteReady=0, in any state other than IDLE, SHALL drop the byte and set oOverrun=1.
REQ-032 oOverrun SHALL be cleared only by reset or by iStart.
REQ-033 oSampleIndex arithmetic SHALL be unsigned IDX_W-bit and SHALL never exceed NUM_GROUPS; there is no wrap-around within a load.
REQ-034 Latency from acceptance of the 12th byte to oPreparingNextSample SHALL be 1 cycle when iNextSample=1 is already high; oWriteSample SHALL follow 1 cycle later.

Reset
REQ-035 While iResetN=0, the block SHALL be in IDLE with byte count 0 and all outputs 0: all lanes, oSampleIndex, oByteReady, oPreparingNextSample, oWriteSample, oDone and oOverrun.
REQ-036 Reset asserted mid-load SHALL abort immediately, discard any partial group, and emit no further write strobes.
REQ-037 After iResetN rises, the block SHALL remain in IDLE until iStart.

Verification
REQ-038 Scenario: reset, iStart, bytes 0x00..0x0B with iNextSample=1 -> oPreparingNextSample pulses, then oWriteSample with input=0x03020100, expected=0x07060504, valid=0x0B0A0908, index 0.
REQ-039 Scenario: full load of 6 groups (72 bytes) -> 6 write strobes with indices 0..5, then oDone=1 and oByteReady=0.
REQ-040 Scenario: iNextSample held 0 for 10 cycles after the 12th byte -> no strobes, outputs stable; strobes occur only after iNextSample rises.
REQ-041 Scenario: a byte offered during REQUEST -> byte dropped, oOverrun=1; the next iStart clears it.
REQ-042 Scenario: iResetN pulsed low after byte 7 of group 2 -> all outputs 0 immediately; after iStart, group index restarts at 0.
REQ-043 Scenario: iStart pulsed during COLLECT -> ignored, byte count and index unchanged.

Source files
------------

// File: rtl/serial_sample_assembler_if.sv
// Byte-stream, downstream-handshake and sample-lane bundle for serial_sample_assembler.
interface serial_sample_assembler_if #(
  parameter int unsigned IDX_W = 32
);
  logic             iByte_unused_guard;
  logic [7:0]       iByte;
  logic             iByteValid;
  logic             oByteReady;
  logic             iStart;
  logic             iNextSample;
  logic             oPreparingNextSample;
  logic             oWriteSample;
  logic [3:0][7:0]  oCurrentSerialInput;
  logic [3:0][7:0]  oCurrentSerialExpectedOutput;
  logic [3:0][7:0]  oCurrentSerialValidOutput;
  logic [IDX_W-1:0] oSampleIndex;
  logic             oDone;
  logic             oOverrun;

  // Source side: feeds bytes, start pulses and downstream idle status.
  modport master (
    output iByte, iByteValid, iStart, iNextSample,
    input  oByteReady, oPreparingNextSample, oWriteSample,
    input  oCurrentSerialInput, oCurrentSerialExpectedOutput, oCurrentSerialValidOutput,
    input  oSampleIndex, oDone, oOverrun
  );

  // Assembler side.
  modport slave (
    input  iByte, iByteValid, iStart, iNextSample,
    output oByteReady, oPreparingNextSample, oWriteSample,
    output oCurrentSerialInput, oCurrentSerialExpectedOutput, oCurrentSerialValidOutput,
    output oSampleIndex, oDone, oOverrun
  );
endinterface

// File: rtl/serial_sample_assembler.sv
// Assembles 12 serial bytes into one 4-lane sample group (input, expected,
// valid-mask) and hands each group to the downstream stage with a
// request/write handshake, NUM_GROUPS groups per load.
module serial_sample_assembler #(
  parameter int unsigned NUM_GROUPS = 6,
  parameter int unsigned IDX_W      = 32
) (
  input logic                   iClock,
  input logic                   iResetN,
  serial_sample_assembler_if.slave bus
);
  localparam int unsigned CNT_W    = 4;
  localparam int unsigned LAST_POS = 11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_COLLECT,
    S_REQUEST,
    S_WRITE,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [3:0][7:0]  in_q, in_d;
  logic [3:0][7:0]  exp_q, exp_d;
  logic [3:0][7:0]  vld_q, vld_d;
  logic             ovr_q, ovr_d;
  logic             prep_q, prep_d;
  logic             wr_q, wr_d;
  logic             ready_q, ready_d;
  logic             done_q, done_d;
  logic             byte_accept;

  // Next-state, datapath and registered-output decode.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    in_d        = in_q;
    exp_d       = exp_q;
    vld_d       = vld_q;
    ovr_d       = ovr_q;
    prep_d      = 1'b0;
    wr_d        = 1'b0;
    byte_accept = ready_q & bus.iByteValid;

    // A byte offered while not ready is lost; flagged until the next start.
    if (bus.iByteValid && !ready_q && (state_q != S_IDLE)) begin
      ovr_d = 1'b1;
    end

    case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.iStart) begin
          cnt_d   = '0;
          idx_d   = '0;
          ovr_d   = 1'b0;
          state_d = S_COLLECT;
        end
      end
      S_COLLECT: begin
        if (byte_accept) begin
          case (cnt_q[3:2])
            2'd0:    in_d[cnt_q[1:0]]  = bus.iByte;
            2'd1:    exp_d[cnt_q[1:0]] = bus.iByte;
            default: vld_d[cnt_q[1:0]] = bus.iByte;
          endcase
          if (cnt_q == CNT_W'(LAST_POS)) begin
            cnt_d   = '0;
            state_d = S_REQUEST;
            // Downstream already idle: request in the first REQUEST cycle.
            prep_d  = bus.iNextSample;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      S_REQUEST: begin
        if (prep_q) begin
          wr_d    = 1'b1;
          state_d = S_WRITE;
        end else if (bus.iNextSample) begin
          prep_d = 1'b1;
        end
      end
      S_WRITE: begin
        idx_d = idx_q + IDX_W'(1);
        if (idx_d == IDX_W'(NUM_GROUPS)) begin
          state_d = S_DONE;
        end else begin
          state_d = S_COLLECT;
        end
      end
      default: state_d = S_IDLE;
    endcase

    ready_d = (state_d == S_COLLECT);
    done_d  = (state_d == S_DONE);
  end

  // State and output registers; reset aborts any load in progress.
  always_ff @(posedge iClock or negedge iResetN) begin
    if (!iResetN) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      in_q    <= '0;
      exp_q   <= '0;
      vld_q   <= '0;
      ovr_q   <= 1'b0;
      prep_q  <= 1'b0;
      wr_q    <= 1'b0;
      ready_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      in_q    <= in_d;
      exp_q   <= exp_d;
      vld_q   <= vld_d;
      ovr_q   <= ovr_d;
      prep_q  <= prep_d;
      wr_q    <= wr_d;
      ready_q <= ready_d;
      done_q  <= done_d;
    end
  end

  assign bus.oByteReady                   = ready_q;
  assign bus.oPreparingNextSample         = prep_q;
  assign bus.oWriteSample                 = wr_q;
  assign bus.oCurrentSerialInput          = in_q;
  assign bus.oCurrentSerialExpectedOutput = exp_q;
  assign bus.oCurrentSerialValidOutput    = vld_q;
  assign bus.oSampleIndex                 = idx_q;
  assign bus.oDone                        = done_q;
  assign bus.oOverrun                     = ovr_q;
endmodule

// File: tb/tb_serial_sample_assembler.sv
// Scoreboard bench for serial_sample_assembler.
module tb_serial_sample_assembler;
  localparam int unsigned NG = 6;
  localparam int unsigned IW = 32;

  typedef struct packed {
    logic [31:0]   in;
    logic [31:0]   ex;
    logic [31:0]   vl;
    logic [IW-1:0] idx;
  } exp_t;

  logic iClock  = 1'b0;
  logic iResetN = 1'b0;
  int   total   = 0;
  int   bad     = 0;
  int   writes_seen = 0;
  logic prev_prep = 1'b0;
  exp_t sb[$];

  serial_sample_assembler_if #(.IDX_W(IW)) bus ();

  serial_sample_assembler #(.NUM_GROUPS(NG), .IDX_W(IW)) dut (
    .iClock  (iClock),
    .iResetN (iResetN),
    .bus     (bus.slave)
  );

  always #5 iClock = ~iClock;

  // Scoreboard: every write strobe must match the oldest fully sent group.
  always @(negedge iClock) begin
    if (iResetN && bus.oWriteSample) begin
      exp_t e;
      writes_seen++;
      total++;
      if (!prev_prep) begin
        bad++;
        $display("FAIL wr_after_prep: write without request pulse the cycle before, got 0 need 1");
      end
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL unexpected_write: strobe with empty scoreboard idx=%0d", bus.oSampleIndex);
      end else begin
        e = sb.pop_front();
        total++;
        if (bus.oCurrentSerialInput !== e.in) begin
          bad++;
          $display("FAIL wr_input: got %h need %h", bus.oCurrentSerialInput, e.in);
        end
        total++;
        if (bus.oCurrentSerialExpectedOutput !== e.ex) begin
          bad++;
          $display("FAIL wr_expected: got %h need %h", bus.oCurrentSerialExpectedOutput, e.ex);
        end
        total++;
        if (bus.oCurrentSerialValidOutput !== e.vl) begin
          bad++;
          $display("FAIL wr_valid: got %h need %h", bus.oCurrentSerialValidOutput, e.vl);
        end
        total++;
        if (bus.oSampleIndex !== e.idx) begin
          bad++;
          $display("FAIL wr_index: got %0d need %0d", bus.oSampleIndex, e.idx);
        end
      end
    end
    prev_prep = iResetN && bus.oPreparingNextSample;
  end

  task automatic tick();
    @(posedge iClock);
    #1;
  endtask

  task automatic pulse_start();
    bus.iStart = 1'b1;
    tick();
    bus.iStart = 1'b0;
  endtask

  // Hold a byte until the DUT accepts it (ready seen before the edge).
  task automatic send_byte(input logic [7:0] b);
    logic rdy;
    int   n;
    bus.iByte      = b;
    bus.iByteValid = 1'b1;
    n = 0;
    rdy = 1'b0;
    while (!rdy && n < 100) begin
      @(negedge iClock);
      rdy = bus.oByteReady;
      tick();
      n++;
    end
    bus.iByteValid = 1'b0;
    if (!rdy) begin
      total++;
      bad++;
      $display("FAIL byte_timeout: byte %h not accepted, ready got 0 need 1", b);
    end
  endtask

  task automatic send_bytes(input logic [7:0] base, input int first, input int last);
    for (int p = first; p <= last; p++) send_byte(8'(base + 8'(p)));
  endtask

  task automatic push_group(input logic [7:0] base, input int idx);
    exp_t e;
    e.in  = {8'(base + 8'd3), 8'(base + 8'd2), 8'(base + 8'd1), base};
    e.ex  = {8'(base + 8'd7), 8'(base + 8'd6), 8'(base + 8'd5), 8'(base + 8'd4)};
    e.vl  = {8'(base + 8'd11), 8'(base + 8'd10), 8'(base + 8'd9), 8'(base + 8'd8)};
    e.idx = IW'(idx);
    sb.push_back(e);
  endtask

  task automatic send_group(input logic [7:0] base, input int idx);
    send_bytes(base, 0, 11);
    push_group(base, idx);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      tick();
      n++;
    end
    tick();
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL drain_timeout: pending groups got %0d need 0", sb.size());
    end
  endtask

  task automatic test_reset();
    bus.iByte = 8'h00; bus.iByteValid = 1'b0; bus.iStart = 1'b0; bus.iNextSample = 1'b0;
    iResetN = 1'b0;
    repeat (2) @(negedge iClock);
    total++;
    if ({bus.oByteReady, bus.oPreparingNextSample, bus.oWriteSample, bus.oDone, bus.oOverrun} !== 5'b0) begin
      bad++;
      $display("FAIL rst_flags: got %b need 00000",
               {bus.oByteReady, bus.oPreparingNextSample, bus.oWriteSample, bus.oDone, bus.oOverrun});
    end
    total++;
    if ({bus.oCurrentSerialInput, bus.oCurrentSerialExpectedOutput, bus.oCurrentSerialValidOutput} !== 96'h0) begin
      bad++;
      $display("FAIL rst_lanes: lanes not zero, got %h", bus.oCurrentSerialInput);
    end
    total++;
    if (bus.oSampleIndex !== IW'(0)) begin
      bad++;
      $display("FAIL rst_index: got %0d need 0", bus.oSampleIndex);
    end
    tick();
    iResetN = 1'b1;
    repeat (3) tick();
    @(negedge iClock);
    total++;
    if (bus.oByteReady !== 1'b0) begin
      bad++;
      $display("FAIL idle_ready: got %b need 0", bus.oByteReady);
    end
    tick();
  endtask

  task automatic test_single_group();
    writes_seen = 0;
    bus.iNextSample = 1'b1;
    pulse_start();
    send_bytes(8'h00, 0, 10);
    push_group(8'h00, 0);
    send_byte(8'h0B);
    @(negedge iClock);
    total++;
    if (bus.oPreparingNextSample !== 1'b1 || bus.oWriteSample !== 1'b0) begin
      bad++;
      $display("FAIL prep_latency: prep/wr got %b%b need 10", bus.oPreparingNextSample, bus.oWriteSample);
    end
    @(negedge iClock);
    total++;
    if (bus.oWriteSample !== 1'b1 || bus.oPreparingNextSample !== 1'b0) begin
      bad++;
      $display("FAIL wr_latency: prep/wr got %b%b need 01", bus.oPreparingNextSample, bus.oWriteSample);
    end
    @(negedge iClock);
    total++;
    if (bus.oSampleIndex !== IW'(1)) begin
      bad++;
      $display("FAIL idx_after_write: got %0d need 1", bus.oSampleIndex);
    end
    tick();
  endtask

  task automatic test_full_load();
    for (int g = 1; g < int'(NG); g++) send_group(8'(8'h10 * g), g);
    wait_drain();
    @(negedge iClock);
    total++;
    if (writes_seen != int'(NG)) begin
      bad++;
      $display("FAIL load_writes: got %0d need %0d", writes_seen, NG);
    end
    total++;
    if (bus.oDone !== 1'b1 || bus.oByteReady !== 1'b0) begin
      bad++;
      $display("FAIL load_done: done/ready got %b%b need 10", bus.oDone, bus.oByteReady);
    end
    total++;
    if (bus.oSampleIndex !== IW'(NG)) begin
      bad++;
      $display("FAIL load_index: got %0d need %0d", bus.oSampleIndex, NG);
    end
    tick();
  endtask

  task automatic test_start_ignored();
    bus.iNextSample = 1'b1;
    pulse_start();
    @(negedge iClock);
    total++;
    if (bus.oDone !== 1'b0 || bus.oByteReady !== 1'b1) begin
      bad++;
      $display("FAIL restart: done/ready got %b%b need 01", bus.oDone, bus.oByteReady);
    end
    tick();
    send_group(8'hA0, 0);
    wait_drain();
    send_bytes(8'hB0, 0, 4);
    pulse_start();
    send_bytes(8'hB0, 5, 11);
    push_group(8'hB0, 1);
    wait_drain();
    total++;
    if (bus.oSampleIndex !== IW'(2)) begin
      bad++;
      $display("FAIL start_ignored_idx: got %0d need 2", bus.oSampleIndex);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] want_in;
    int          n;
    bus.iNextSample = 1'b0;
    send_group(8'hC0, 2);
    want_in = 32'hC3C2C1C0;
    for (int c = 0; c < 10; c++) begin
      @(negedge iClock);
      total++;
      if (bus.oWriteSample !== 1'b0 || bus.oPreparingNextSample !== 1'b0 ||
          bus.oCurrentSerialInput !== want_in || bus.oSampleIndex !== IW'(2)) begin
        bad++;
        $display("FAIL hold_stable c=%0d: wr=%b prep=%b in=%h idx=%0d need 0 0 %h 2",
                 c, bus.oWriteSample, bus.oPreparingNextSample, bus.oCurrentSerialInput, want_in, bus.oSampleIndex);
      end
    end
    tick();
    bus.iNextSample = 1'b1;
    n = 0;
    while (bus.oPreparingNextSample !== 1'b1 && n < 20) begin
      @(negedge iClock);
      n++;
    end
    total++;
    if (bus.oPreparingNextSample !== 1'b1) begin
      bad++;
      $display("FAIL prep_timeout: prep got 0 need 1");
    end
    @(negedge iClock);
    total++;
    if (bus.oPreparingNextSample !== 1'b0) begin
      bad++;
      $display("FAIL prep_width: prep got 1 need 0 in second cycle");
    end
    wait_drain();
  endtask

  task automatic test_overrun();
    bus.iNextSample = 1'b0;
    send_group(8'h30, 3);
    tick();
    bus.iByte = 8'hEE;
    bus.iByteValid = 1'b1;
    tick();
    bus.iByteValid = 1'b0;
    @(negedge iClock);
    total++;
    if (bus.oOverrun !== 1'b1 || bus.oByteReady !== 1'b0) begin
      bad++;
      $display("FAIL overrun_set: ovr/ready got %b%b need 10", bus.oOverrun, bus.oByteReady);
    end
    tick();
    bus.iNextSample = 1'b1;
    wait_drain();
    send_group(8'h50, 4);
    send_group(8'h60, 5);
    wait_drain();
    @(negedge iClock);
    total++;
    if (bus.oOverrun !== 1'b1 || bus.oDone !== 1'b1) begin
      bad++;
      $display("FAIL overrun_sticky: ovr/done got %b%b need 11", bus.oOverrun, bus.oDone);
    end
    tick();
    pulse_start();
    @(negedge iClock);
    total++;
    if (bus.oOverrun !== 1'b0 || bus.oSampleIndex !== IW'(0) || bus.oDone !== 1'b0) begin
      bad++;
      $display("FAIL overrun_clear: ovr=%b idx=%0d done=%b need 0 0 0",
               bus.oOverrun, bus.oSampleIndex, bus.oDone);
    end
    tick();
  endtask

  task automatic test_reset_midload();
    bus.iNextSample = 1'b1;
    send_group(8'h70, 0);
    send_group(8'h80, 1);
    wait_drain();
    send_bytes(8'h90, 0, 7);
    iResetN = 1'b0;
    #1;
    total++;
    if ({bus.oByteReady, bus.oPreparingNextSample, bus.oWriteSample, bus.oDone, bus.oOverrun} !== 5'b0 ||
        bus.oSampleIndex !== IW'(0) || bus.oCurrentSerialInput !== 32'h0 ||
        bus.oCurrentSerialExpectedOutput !== 32'h0 || bus.oCurrentSerialValidOutput !== 32'h0) begin
      bad++;
      $display("FAIL midload_reset: outputs not zero, idx=%0d in=%h ready=%b",
               bus.oSampleIndex, bus.oCurrentSerialInput, bus.oByteReady);
    end
    repeat (2) tick();
    iResetN = 1'b1;
    repeat (4) tick();
    total++;
    if (writes_seen != 0 && sb.size() != 0) begin
      bad++;
      $display("FAIL midload_pending: pending got %0d need 0", sb.size());
    end
    pulse_start();
    send_group(8'hD0, 0);
    wait_drain();
    total++;
    if (bus.oSampleIndex !== IW'(1)) begin
      bad++;
      $display("FAIL midload_restart_idx: got %0d need 1", bus.oSampleIndex);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_group();
    test_full_load();
    test_start_ignored();
    test_backpressure();
    test_overrun();
    test_reset_midload();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
